pe_mac_cell: RTL and testbench

//  Systolic-array processing element: one signed fixed-point multiply-accumulate, OUT = X*W + D.
//  X enters from the left neighbour and is forwarded right. W is the stationary weight from DDR.
//  D is the partial sum from the cell above. The result is shifted down to the cell below.
//  A multi-cycle sequential multiplier keeps area small; handshakes are valid pulses / done flags.

---
 rtl/pe_mac_cell_pkg.sv | 20 ++
 rtl/pe_seq_mult.sv | 55 +++++
 rtl/pe_mac_cell.sv | 113 +++++++++++
 tb/tb_pe_mac_cell.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_cell_pkg.sv
// Shared definitions for the systolic PE: data widths, FSM states, Q-format slice.
package pe_mac_cell_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2,
        ST_ADD  = 2'd3
    } pe_state_e;

    // Bring a full-width Q4.26 product back to Q2.13: keep the sign, drop the
    // two integer guard bits below it (no saturation), truncate the fraction.
    function automatic logic [DATA_W-1:0] q_slice(input logic [2*DATA_W-1:0] prod);
        return {prod[2*DATA_W-1], prod[FRAC_W+DATA_W-2:FRAC_W]};
    endfunction

endpackage

// File: rtl/pe_seq_mult.sv
// Radix-2 signed shift-add multiplier, one multiplier bit per clock.
// I_START loads the operands; O_DONE is high during the cycle whose closing
// edge writes the final product, so O_PROD is valid from the following cycle.
module pe_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_START,
    input  logic [WIDTH-1:0]   I_A,
    input  logic [WIDTH-1:0]   I_B,
    output logic               O_DONE,
    output logic [2*WIDTH-1:0] O_PROD
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;

    // Partial product for this step; the multiplier MSB carries weight -2^(WIDTH-1)
    always_comb begin
        addend = '0;
        if (mplier[0]) begin
            addend = (cnt == CNT_W'(1)) ? -mcand : mcand;
        end
    end

    // Down-counting iteration register, shifting multiplicand/multiplier, accumulator
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (I_START) begin
            cnt    <= CNT_W'(WIDTH);
            mcand  <= {{WIDTH{I_A[WIDTH-1]}}, I_A};
            mplier <= I_B;
            acc    <= '0;
        end else if (cnt != '0) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    assign O_DONE = (cnt == CNT_W'(1));
    assign O_PROD = acc;

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic-array PE: OUT = X*W + D in Q2.13, X forwarded right, result shifted down.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for X, W and D valid together; accept captures all
//  MUL     | sequential multiplier running (16 clocks)
//  DONE    | product ready, O_MUL_DONE pulse; result register loads here
//  ADD     | O_OUT shows the new result, O_OUT_VLD pulse
module pe_mac_cell
    import pe_mac_cell_pkg::*;
(
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_X_VLD,
    input  logic [DATA_W-1:0] I_X,
    input  logic              I_W_VLD,
    input  logic [DATA_W-1:0] I_W,
    input  logic              I_D_VLD,
    input  logic [DATA_W-1:0] I_D,
    output logic              O_X_VLD,
    output logic [DATA_W-1:0] O_X,
    output logic              O_MUL_DONE,
    output logic              O_OUT_VLD,
    output logic [DATA_W-1:0] O_OUT
);

    pe_state_e             state;
    pe_state_e             state_nxt;
    logic                  all_vld;
    logic                  accept;
    logic                  load_out;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     d_q;

    assign all_vld = I_X_VLD & I_W_VLD & I_D_VLD;

    // State register
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (all_vld)  state_nxt = ST_MUL;
            ST_MUL:  if (mul_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_ADD;
            ST_ADD:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode from the registered state
    always_comb begin
        accept     = 1'b0;
        load_out   = 1'b0;
        O_MUL_DONE = 1'b0;
        O_OUT_VLD  = 1'b0;
        unique case (state)
            ST_IDLE: accept = all_vld;
            ST_MUL:  ;
            ST_DONE: begin
                O_MUL_DONE = 1'b1;
                load_out   = 1'b1;
            end
            ST_ADD:  O_OUT_VLD = 1'b1;
            default: ;
        endcase
    end

    // Operand capture; X is forwarded straight from its capture register
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_X     <= '0;
            O_X_VLD <= 1'b0;
            d_q     <= '0;
        end else begin
            O_X_VLD <= accept;
            if (accept) begin
                O_X <= I_X;
                d_q <= I_D;
            end
        end
    end

    // Result register: truncated product plus partial sum, wrapping
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_OUT <= '0;
        end else if (load_out) begin
            O_OUT <= q_slice(prod) + d_q;
        end
    end

    pe_seq_mult #(
        .WIDTH (DATA_W)
    ) u_mult (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_START (accept),
        .I_A     (I_X),
        .I_B     (I_W),
        .O_DONE  (mul_done),
        .O_PROD  (prod)
    );

endmodule

// File: tb/tb_pe_mac_cell.sv
// Scoreboard bench for pe_mac_cell: a driver issues operations and queues the
// expected forwarded X, done timing and result; a negedge monitor checks them.
module tb_pe_mac_cell;

    logic        I_CLK = 1'b0;
    logic        I_RST_N;
    logic        I_X_VLD, I_W_VLD, I_D_VLD;
    logic [15:0] I_X, I_W, I_D;
    logic        O_X_VLD, O_MUL_DONE, O_OUT_VLD;
    logic [15:0] O_X, O_OUT;

    pe_mac_cell dut (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_X_VLD    (I_X_VLD),
        .I_X        (I_X),
        .I_W_VLD    (I_W_VLD),
        .I_W        (I_W),
        .I_D_VLD    (I_D_VLD),
        .I_D        (I_D),
        .O_X_VLD    (O_X_VLD),
        .O_X        (O_X),
        .O_MUL_DONE (O_MUL_DONE),
        .O_OUT_VLD  (O_OUT_VLD),
        .O_OUT      (O_OUT)
    );

    initial forever #5 I_CLK = ~I_CLK;

    typedef struct {
        int          acc;
        logic [15:0] x;
        logic [15:0] o;
    } exp_t;

    exp_t q_x[$];
    exp_t q_d[$];
    exp_t q_o[$];
    exp_t mon_e;

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int last_acc = -100;
    bit mon_en   = 1'b0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Golden model: real signed product, Q-format truncation, wrapping add
    function automatic logic [15:0] ref_mac(input logic [15:0] x, input logic [15:0] w,
                                            input logic [15:0] d);
        longint      p;
        logic [31:0] p32;
        logic [31:0] s;
        p   = longint'($signed(x)) * longint'($signed(w));
        p32 = p[31:0];
        s   = ((p32 >> 13) & 32'h0000_7FFF) | (p32[31] ? 32'h0000_8000 : 32'h0);
        return 16'(s + {16'h0, d});
    endfunction

    // Issue one op at a negedge, wait (bounded) for O_MUL_DONE, drop valids,
    // return one cycle later. The DUT can accept at the first edge with
    // valids high, but no sooner than 19 edges after the previous accept.
    task automatic issue(input logic [15:0] x, input logic [15:0] w,
                         input logic [15:0] d, input logic [15:0] exp_o);
        exp_t e;
        int   n;
        I_X = x; I_W = w; I_D = d;
        I_X_VLD = 1'b1; I_W_VLD = 1'b1; I_D_VLD = 1'b1;
        e.acc = (cyc + 1 > last_acc + 19) ? cyc + 1 : last_acc + 19;
        e.x   = x;
        e.o   = exp_o;
        last_acc = e.acc;
        q_x.push_back(e);
        q_d.push_back(e);
        q_o.push_back(e);
        n = 0;
        do begin
            @(negedge I_CLK);
            n++;
        end while (!O_MUL_DONE && n < 40);
        chk("done_seen", 32'(O_MUL_DONE), 32'd1);
        I_X_VLD = 1'b0; I_W_VLD = 1'b0; I_D_VLD = 1'b0;
        @(negedge I_CLK);
    endtask

    // Monitor: pop and compare whenever the DUT presents a pulse
    always @(negedge I_CLK) begin
        if (mon_en && I_RST_N) begin
            if (O_X_VLD) begin
                chk("x_pending", {31'b0, q_x.size() != 0}, 32'd1);
                if (q_x.size() != 0) begin
                    mon_e = q_x.pop_front();
                    chk("x_val", 32'(O_X), 32'(mon_e.x));
                    chk("x_lat", cyc, mon_e.acc);
                end
            end
            if (O_MUL_DONE) begin
                chk("done_pending", {31'b0, q_d.size() != 0}, 32'd1);
                if (q_d.size() != 0) begin
                    mon_e = q_d.pop_front();
                    chk("done_lat", cyc, mon_e.acc + 16);
                end
            end
            if (O_OUT_VLD) begin
                chk("out_pending", {31'b0, q_o.size() != 0}, 32'd1);
                if (q_o.size() != 0) begin
                    mon_e = q_o.pop_front();
                    chk("out_val", 32'(O_OUT), 32'(mon_e.o));
                    chk("out_lat", cyc, mon_e.acc + 17);
                end
            end
        end
    end

    logic [15:0] corners [6];
    logic [15:0] rx, rw, rd;
    int          pulses;

    function automatic logic [15:0] pick(input logic [15:0] c0, input logic [15:0] c1,
                                         input logic [15:0] c2, input logic [15:0] c3);
        case ($urandom_range(0, 7))
            0: return c0;
            1: return c1;
            2: return c2;
            3: return c3;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        corners = '{16'h8000, 16'h7FFF, 16'h0000, 16'h2000, 16'hE000, 16'hFFFF};

        // Reset held with random inputs, valids included
        I_RST_N = 1'b0;
        I_X_VLD = 1'b0; I_W_VLD = 1'b0; I_D_VLD = 1'b0;
        I_X = '0; I_W = '0; I_D = '0;
        repeat (5) begin
            @(negedge I_CLK);
            I_X = 16'($urandom); I_W = 16'($urandom); I_D = 16'($urandom);
            I_X_VLD = 1'($urandom); I_W_VLD = 1'b1; I_D_VLD = 1'b1;
        end
        @(negedge I_CLK);
        chk("rst_x",        32'(O_X),        32'd0);
        chk("rst_x_vld",    32'(O_X_VLD),    32'd0);
        chk("rst_mul_done", 32'(O_MUL_DONE), 32'd0);
        chk("rst_out_vld",  32'(O_OUT_VLD),  32'd0);
        chk("rst_out",      32'(O_OUT),      32'd0);
        I_X_VLD = 1'b0; I_W_VLD = 1'b0; I_D_VLD = 1'b0;
        I_RST_N = 1'b1;
        @(negedge I_CLK);
        mon_en = 1'b1;

        // Directed vectors with hand-derived results
        issue(16'h2000, 16'h2000, 16'h0000, 16'h2000);
        issue(16'hE000, 16'h2000, 16'h1000, 16'hF000);
        issue(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFF7);
        issue(16'h8000, 16'h8000, 16'h0123, 16'h0123);

        // Partial valid set: no accept for 10 cycles, then complete it
        repeat (2) @(negedge I_CLK);
        I_X = 16'h1000; I_W = 16'h4000; I_D = 16'h0100;
        I_X_VLD = 1'b1; I_W_VLD = 1'b1; I_D_VLD = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge I_CLK);
            pulses += int'(O_X_VLD) + int'(O_MUL_DONE) + int'(O_OUT_VLD);
        end
        chk("partial_no_pulse", pulses, 0);
        issue(16'h1000, 16'h4000, 16'h0100, 16'h2100);

        // Reset in the middle of a multiply aborts it silently
        repeat (3) @(negedge I_CLK);
        mon_en  = 1'b0;
        I_X = 16'h1234; I_W = 16'h4321; I_D = 16'h0F0F;
        I_X_VLD = 1'b1; I_W_VLD = 1'b1; I_D_VLD = 1'b1;
        @(negedge I_CLK);
        I_X_VLD = 1'b0; I_W_VLD = 1'b0; I_D_VLD = 1'b0;
        repeat (5) @(negedge I_CLK);
        I_RST_N = 1'b0;
        #1;
        chk("midrst_x",        32'(O_X),        32'd0);
        chk("midrst_out",      32'(O_OUT),      32'd0);
        chk("midrst_mul_done", 32'(O_MUL_DONE), 32'd0);
        repeat (2) @(negedge I_CLK);
        I_RST_N = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge I_CLK);
            pulses += int'(O_X_VLD) + int'(O_MUL_DONE) + int'(O_OUT_VLD);
        end
        chk("midrst_no_pulse", pulses, 0);
        last_acc = -100;
        mon_en   = 1'b1;

        // Back-to-back random operations against the golden model
        for (int i = 0; i < 1000; i++) begin
            rx = pick(corners[0], corners[1], corners[4], corners[3]);
            rw = pick(corners[0], corners[1], corners[5], corners[2]);
            rd = pick(corners[1], corners[0], corners[2], corners[4]);
            issue(rx, rw, rd, ref_mac(rx, rw, rd));
        end

        repeat (5) @(negedge I_CLK);
        chk("drain_x",    32'(q_x.size()), 32'd0);
        chk("drain_done", 32'(q_d.size()), 32'd0);
        chk("drain_out",  32'(q_o.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
